// File: rtl/aes_mask_rng.sv
// Mask source for the protected AES32 unit. It runs a 64-bit Galois LFSR with warm-up, draw budget and reseed.
// Define AES_RNG_HEALTH_EN to add stuck-state/repeat-word health checks and a HALT state.
module aes_mask_rng #(
  parameter int unsigned RAND_WIDTH      = 26,
  parameter int unsigned WARMUP_CYCLES   = 16,
  parameter int unsigned RESEED_INTERVAL = 1024,
  parameter logic [63:0] DEFAULT_SEED    = 64'hACE1_2468_9BDF_1357
) (
  input  logic                  clk_i,
  input  logic                  rst_i,
  input  logic [63:0]           seed_i,
  input  logic                  seed_valid_i,
  output logic                  seed_ready_o,
  output logic [RAND_WIDTH-1:0] rand_o,
  output logic                  rand_valid_o,
  input  logic                  rand_ready_i,
  output logic                  reseed_req_o,
  output logic                  health_err_o
);

  localparam int unsigned WarmW = $clog2(WARMUP_CYCLES + 1);
  localparam int unsigned CntW  = $clog2(RESEED_INTERVAL + 1);
  // Feedback mask for x^64+x^63+x^61+x^60+1, right-shifting form.
  localparam logic [63:0] Taps  = 64'hD800_0000_0000_0000;

`ifdef AES_RNG_HEALTH_EN
  typedef enum logic [1:0] {StWarmup, StRun, StHalt} fsm_e;
`else
  typedef enum logic [0:0] {StWarmup, StRun} fsm_e;
`endif

  function automatic logic [63:0] lfsr_adv(input logic [63:0] s);
    logic [63:0] t;
    t = s;
    for (int unsigned i = 0; i < RAND_WIDTH; i++) begin
      t = t[0] ? ((t >> 1) ^ Taps) : (t >> 1);
    end
    return t;
  endfunction

  fsm_e                  fsm_q, fsm_d;
  logic [63:0]           state_q, state_d;
  logic [WarmW-1:0]      warm_q, warm_d;
  logic [CntW-1:0]       draws_q, draws_d;
  logic [RAND_WIDTH-1:0] rand_q, rand_d;
  logic                  valid_q, valid_d;
  logic                  req_q, req_d;
  logic [63:0]           state_next;
  logic [RAND_WIDTH-1:0] word_next;
  logic                  do_update, do_load, health_fail;
`ifdef AES_RNG_HEALTH_EN
  logic                  err_q, err_d;
`endif

  always_comb begin
    fsm_d       = fsm_q;
    state_d     = state_q;
    warm_d      = warm_q;
    draws_d     = draws_q;
    rand_d      = rand_q;
    valid_d     = valid_q;
    do_update   = 1'b0;
    do_load     = 1'b0;
    health_fail = 1'b0;
    state_next  = lfsr_adv(state_q);
    word_next   = state_next[RAND_WIDTH-1:0];
`ifdef AES_RNG_HEALTH_EN
    err_d       = err_q;
`endif

    if (valid_q && rand_ready_i && (draws_q != CntW'(RESEED_INTERVAL))) begin
      draws_d = draws_q + CntW'(1);
    end

    unique case (fsm_q)
      StWarmup: begin
        do_update = 1'b1;
        if (warm_q == WarmW'(WARMUP_CYCLES - 1)) begin
          do_load = 1'b1;
        end else begin
          warm_d = warm_q + WarmW'(1);
        end
      end
      StRun: begin
        if (!valid_q || rand_ready_i) begin
          do_update = 1'b1;
          do_load   = 1'b1;
        end
      end
`ifdef AES_RNG_HEALTH_EN
      StHalt: ;
`endif
      default: ;
    endcase

`ifdef AES_RNG_HEALTH_EN
    health_fail = do_update && ((state_next == 64'h0) || (word_next == rand_q));
    if (health_fail) begin
      fsm_d   = StHalt;
      valid_d = 1'b0;
      err_d   = 1'b1;
    end
`endif

    if (do_update && !health_fail) begin
      state_d = state_next;
      if (do_load) begin
        rand_d  = word_next;
        valid_d = 1'b1;
        fsm_d   = StRun;
      end
    end

    req_d = (draws_d == CntW'(RESEED_INTERVAL));

    // Seed wins over generation; a transfer in the same cycle still reaches the consumer.
    if (seed_valid_i) begin
      state_d = (seed_i == 64'h0) ? DEFAULT_SEED : seed_i;
      fsm_d   = StWarmup;
      warm_d  = '0;
      valid_d = 1'b0;
      draws_d = '0;
      req_d   = 1'b0;
`ifdef AES_RNG_HEALTH_EN
      err_d   = 1'b0;
`endif
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fsm_q   <= StWarmup;
      state_q <= DEFAULT_SEED;
      warm_q  <= '0;
      draws_q <= '0;
      rand_q  <= '0;
      valid_q <= 1'b0;
      req_q   <= 1'b0;
`ifdef AES_RNG_HEALTH_EN
      err_q   <= 1'b0;
`endif
    end else begin
      fsm_q   <= fsm_d;
      state_q <= state_d;
      warm_q  <= warm_d;
      draws_q <= draws_d;
      rand_q  <= rand_d;
      valid_q <= valid_d;
      req_q   <= req_d;
`ifdef AES_RNG_HEALTH_EN
      err_q   <= err_d;
`endif
    end
  end

  assign seed_ready_o = 1'b1;
  assign rand_o       = rand_q;
  assign rand_valid_o = valid_q;
  assign reseed_req_o = req_q;
`ifdef AES_RNG_HEALTH_EN
  assign health_err_o = err_q;
`else
  assign health_err_o = 1'b0;
`endif

endmodule

// File: tb/tb_aes_mask_rng.sv
// Directed bench for aes_mask_rng: reset release, stalls, draw budget, reseeds and mid-stream reset.
// The health-check scenario runs only when AES_RNG_HEALTH_EN is defined.
module tb_aes_mask_rng;

  localparam int unsigned RW = 26;
  localparam int unsigned WU = 16;
  localparam int unsigned RI = 4;
  localparam logic [63:0] DSEED = 64'hACE1_2468_9BDF_1357;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic [63:0]   seed = 64'h0;
  logic          sv = 1'b0;
  logic          rdy = 1'b0;
  logic          seed_rdy;
  logic [RW-1:0] rand_w;
  logic          rvalid, req, herr;

  int total = 0;
  int bad = 0;

  logic [RW-1:0] gdef[40];
  logic [RW-1:0] gone[8];
  logic [RW-1:0] gfive[4];

  typedef struct {
    logic        rdy;
    logic        sv;
    logic [63:0] seed;
    logic        ev;
    int          eidx;
    logic        ereq;
  } vec_t;
  vec_t tbl[16];

  aes_mask_rng #(
    .RAND_WIDTH     (RW),
    .WARMUP_CYCLES  (WU),
    .RESEED_INTERVAL(RI),
    .DEFAULT_SEED   (DSEED)
  ) dut (
    .clk_i       (clk),
    .rst_i       (rst),
    .seed_i      (seed),
    .seed_valid_i(sv),
    .seed_ready_o(seed_rdy),
    .rand_o      (rand_w),
    .rand_valid_o(rvalid),
    .rand_ready_i(rdy),
    .reseed_req_o(req),
    .health_err_o(herr)
  );

  always #5 clk = ~clk;

  // One Galois step: shift right and fold the dropped bit into taps 63, 62, 60 and 59.
  function automatic logic [63:0] adv(input logic [63:0] s);
    logic [63:0] t;
    logic        fb;
    t = s;
    for (int i = 0; i < int'(RW); i++) begin
      fb = t[0];
      t  = {1'b0, t[63:1]};
      if (fb) begin
        t[63] = ~t[63];
        t[62] = ~t[62];
        t[60] = ~t[60];
        t[59] = ~t[59];
      end
    end
    return t;
  endfunction

  function automatic logic [63:0] warm(input logic [63:0] s);
    logic [63:0] t;
    t = s;
    for (int i = 0; i < int'(WU); i++) t = adv(t);
    return t;
  endfunction

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", nm, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  // Caller has raised rst; checks reset values and then the sequence from DEFAULT_SEED.
  task automatic rst_seq(input string tag);
    tick();
    chk({tag, " rst rand"}, 64'(rand_w), 64'h0);
    chk({tag, " rst valid"}, 64'(rvalid), 64'h0);
    chk({tag, " rst req"}, 64'(req), 64'h0);
    chk({tag, " rst err"}, 64'(herr), 64'h0);
    chk({tag, " seed_ready"}, 64'(seed_rdy), 64'h1);
    rst = 1'b0;
    rdy = 1'b1;
    for (int c = 1; c <= 21; c++) begin
      tick();
      chk($sformatf("%s c%0d valid", tag, c), 64'(rvalid), 64'(c >= int'(WU)));
      if (c >= int'(WU)) chk($sformatf("%s c%0d word", tag, c), 64'(rand_w), 64'(gdef[c-WU]));
      chk($sformatf("%s c%0d req", tag, c), 64'(req), 64'(c >= int'(WU + RI)));
      if (c == 21) rdy = 1'b0;
    end
  endtask

  initial begin
    logic [63:0] st;
    st = warm(DSEED);
    for (int k = 0; k < 40; k++) begin gdef[k] = st[RW-1:0]; st = adv(st); end
    st = warm(64'h1);
    for (int k = 0; k < 8; k++) begin gone[k] = st[RW-1:0]; st = adv(st); end
    st = warm(64'h5);
    for (int k = 0; k < 4; k++) begin gfive[k] = st[RW-1:0]; st = adv(st); end

    for (int i = 0; i < 9; i++) tbl[i] = '{1'b0, 1'b0, 64'h0, 1'b1, 5, 1'b1};
    tbl[9]  = '{1'b1, 1'b0, 64'h0, 1'b1, 5, 1'b1};
    tbl[10] = '{1'b0, 1'b0, 64'h0, 1'b1, 6, 1'b1};
    tbl[11] = '{1'b1, 1'b0, 64'h0, 1'b1, 6, 1'b1};
    tbl[12] = '{1'b1, 1'b0, 64'h0, 1'b1, 7, 1'b1};
    tbl[13] = '{1'b0, 1'b0, 64'h0, 1'b1, 8, 1'b1};
    tbl[14] = '{1'b0, 1'b1, 64'h1, 1'b1, 8, 1'b1};
    tbl[15] = '{1'b1, 1'b0, 64'h0, 1'b0, -1, 1'b0};

    // Reset release, warm-up timing and first words; draw budget reached after 4 transfers.
    rst_seq("boot");

    // Ten stalled cycles, single-pulse advance, then a seed of 1.
    for (int i = 0; i < 16; i++) begin
      tick();
      chk($sformatf("tbl%0d valid", i), 64'(rvalid), 64'(tbl[i].ev));
      if (tbl[i].eidx >= 0) chk($sformatf("tbl%0d word", i), 64'(rand_w), 64'(gdef[tbl[i].eidx]));
      chk($sformatf("tbl%0d req", i), 64'(req), 64'(tbl[i].ereq));
      rdy  = tbl[i].rdy;
      sv   = tbl[i].sv;
      seed = tbl[i].seed;
    end

    // Warm-up from seed 1; the fourth transfer coincides with a zero seed.
    for (int k = 1; k <= 19; k++) begin
      tick();
      chk($sformatf("s1 k%0d valid", k), 64'(rvalid), 64'(k >= int'(WU)));
      chk($sformatf("s1 k%0d req", k), 64'(req), 64'h0);
      if (k >= int'(WU)) chk($sformatf("s1 k%0d word", k), 64'(rand_w), 64'(gone[k-WU]));
      if (k == 19) begin sv = 1'b1; seed = 64'h0; end
    end

    // Zero seed falls back to DEFAULT_SEED; counter restarts from 0.
    for (int j = 0; j <= 23; j++) begin
      tick();
      sv = 1'b0;
      chk($sformatf("s0 j%0d valid", j), 64'(rvalid), 64'(j >= int'(WU)));
      chk($sformatf("s0 j%0d req", j), 64'(req), 64'(j >= int'(WU + RI)));
      if (j >= int'(WU)) chk($sformatf("s0 j%0d word", j), 64'(rand_w), 64'(gdef[j-WU]));
      if (j == 23) rst = 1'b1;
    end

    // One-cycle reset after 7 transfers restarts the stream.
    rst_seq("rerst");

`ifdef AES_RNG_HEALTH_EN
    force dut.state_q = 64'h0;
    rdy = 1'b1;
    tick();
    release dut.state_q;
    for (int h = 0; h < 4; h++) begin
      chk($sformatf("halt h%0d err", h), 64'(herr), 64'h1);
      chk($sformatf("halt h%0d valid", h), 64'(rvalid), 64'h0);
      tick();
    end
    sv = 1'b1;
    seed = 64'h5;
    tick();
    sv = 1'b0;
    chk("s5 err", 64'(herr), 64'h0);
    for (int k = 1; k <= 16; k++) begin
      tick();
      chk($sformatf("s5 k%0d valid", k), 64'(rvalid), 64'(k >= int'(WU)));
      if (k >= int'(WU)) chk("s5 word", 64'(rand_w), 64'(gfive[0]));
    end
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
